ram_read_check: RTL and testbench
=================================

// Module: ram_read_check
// PURPOSE
//  Read-back checker placed downstream of the PL BRAM write engine. When the
//   engine signals write_end, this block sweeps the same BRAM region through
//   its own port, regenerates the expected ramp (init_data + word index) and
//   compares each word. Error count and first-error details go to the PS
//   register bank.
// PARAMETERS
//  RD_LAT   1   BRAM read latency in cycles, from ram_en/ram_addr to valid ram_din (1..3)
//  ERR_W    16  width of the error counter (saturating)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   asynchronous, active-high reset
//  ram_din         in   32  BRAM read data
//  ram_en          out  1   BRAM enable
//  ram_we          out  4   BRAM byte write enable (tied 4'h0)
//  ram_rst         out  1   BRAM reset (tied 1'b0)
//  ram_addr        out  32  BRAM byte address
//  chk_start       in   1   start pulse or level; sampled only in IDLE
//  start_addr      in   32  first byte address; word aligned
//  len             in   32  region length in bytes; len[1:0] ignored
//  init_data       in   32  expected value of word 0
//  chk_busy        out  1   high from the start-sampling edge until done
//  chk_done        out  1   one-cycle pulse at completion
//  chk_pass        out  1   1 if err_cnt==0; valid at chk_done, held until the next start
//  err_cnt         out  ERR_W  number of mismatching words, saturates at all-ones
//  first_err_addr  out  32  byte address of the first mismatch (0 if none)
//  first_err_data  out  32  data read at first_err_addr (0 if none)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; delay line cleared.
//  FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//  IDLE: on chk_start, latch start_addr/len/init_data, set N = len>>2.
//   - Clear err_cnt, first_err_*, chk_pass; set chk_busy=1.
//   - If N==0, go directly to DONE with chk_pass=1.
//   - Otherwise ram_en<=1, ram_addr<=start_addr, go to ISSUE.
//  ISSUE: one word per cycle; ram_addr += 4.
//   - An RD_LAT-deep delay line carries {valid, addr, expected} alongside each read.
//   - Expected value is init_data+k, 32-bit wrap-around.
//   - After word N-1 is issued: ram_en<=0, go to DRAIN.
//  Compare: when the delayed valid is high, compare ram_din against the delayed expected.
//   - On mismatch, increment err_cnt (saturating).
//   - On the first mismatch only, capture first_err_addr and first_err_data.
//  DRAIN: wait until the delay line is empty (RD_LAT cycles), then go to DONE.
//  DONE: chk_done=1 for one cycle, chk_pass=(err_cnt==0), chk_busy=0, go to IDLE.
//  Latency: chk_done is high N+RD_LAT+2 cycles after the start-sampling edge.
//   For N==0, chk_done is high 2 cycles after that edge.
//  chk_start while busy: ignored; no restart, no error.
//   A start held high through DONE re-triggers in the following IDLE cycle.
//  Address wrap: ram_addr wraps modulo 2^32 with no error.
//   len and start_addr are not range-checked.
//  Reset mid-run: immediate abort. Outputs go to reset values; no chk_done pulse.
//  ram_we is never nonzero: this block never writes the BRAM.
// CONFIGURATION
//  CHK_ERR_INJECT_EN defined:
//   - Adds input port err_inj (1 bit), sampled together with chk_start.
//   - If err_inj was 1, the expected value of word 0 is XORed with 32'h1.
//   - Result on clean memory: exactly one error, at start_addr.
//  CHK_ERR_INJECT_EN undefined: port absent; expected values are never modified.
// TESTING
//  1. BRAM preloaded with ramp 0x100+k, 16 words at 0x0; start, len=64, init=0x100
//     -> pass=1, err_cnt=0, done at cycle 16+RD_LAT+2.
//  2. Same ramp, but word 5 corrupted to 0xDEAD
//     -> err_cnt=1, first_err_addr=0x14, first_err_data=0xDEAD, pass=0.
//  3. len=0, and separately len=3
//     -> no ram_en, done 2 cycles after start, pass=1, err_cnt=0.
//  4. init=0xFFFFFFFE, 4 words, memory holding FFFFFFFE, FFFFFFFF, 0, 1
//     -> pass=1 (expected value wraps).
//  5. chk_start pulsed again mid-run, then rst asserted mid-run
//     -> second start ignored; after reset, outputs are 0, no done; a later start runs normally.
//  6. (CHK_ERR_INJECT_EN) clean ramp, err_inj=1
//     -> err_cnt=1, first_err_addr=start_addr.

Source files
------------

// File: rtl/ram_read_check.sv
// ram_read_check: sweeps a BRAM region after the write engine finishes and
// compares every word against the ramp init_data + word_index.
// Optional feature macro: CHK_ERR_INJECT_EN adds port err_inj, which flips
// bit 0 of the expected value of word 0 so the error path can be exercised.
module ram_read_check #(
    parameter int RD_LAT = 1,   // BRAM read latency, 1..3
    parameter int ERR_W  = 16   // saturating error counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ram_din,
    output logic             ram_en,
    output logic [3:0]       ram_we,
    output logic             ram_rst,
    output logic [31:0]      ram_addr,
    input  logic             chk_start,
`ifdef CHK_ERR_INJECT_EN
    input  logic             err_inj,
`endif
    input  logic [31:0]      start_addr,
    input  logic [31:0]      len,
    input  logic [31:0]      init_data,
    output logic             chk_busy,
    output logic             chk_done,
    output logic             chk_pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [31:0]      first_err_addr,
    output logic [31:0]      first_err_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    // One entry per outstanding read, travelling alongside the BRAM pipeline.
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] expd;
    } tag_t;

    state_t           state_q, state_d;
    logic             ram_en_q, ram_en_d;
    logic [31:0]      ram_addr_q, ram_addr_d;
    logic [31:0]      idx_q, idx_d;          // index of the word currently on ram_addr
    logic [31:0]      n_q, n_d;              // number of words in the region
    logic [31:0]      init_q, init_d;
    logic [1:0]       drain_cnt_q, drain_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]      first_addr_q, first_addr_d;
    logic [31:0]      first_data_q, first_data_d;
    tag_t             dly_q [RD_LAT];
    tag_t             dly_d [RD_LAT];
    logic [31:0]      exp_cur;
`ifdef CHK_ERR_INJECT_EN
    logic             inj_q, inj_d;
`endif

    // Byte-granular length bits below a word are don't-care.
    logic len_lsb_unused;
    assign len_lsb_unused = ^len[1:0];

    // Next-state, delay line shift and compare logic.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement leaves one unassigned and infers a latch.
        state_d      = state_q;
        ram_en_d     = ram_en_q;
        ram_addr_d   = ram_addr_q;
        idx_d        = idx_q;
        n_d          = n_q;
        init_d       = init_q;
        drain_cnt_d  = drain_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        first_addr_d = first_addr_q;
        first_data_d = first_data_q;
`ifdef CHK_ERR_INJECT_EN
        inj_d        = inj_q;
`endif

        // Expected ramp value for the word being issued, 32-bit wrap-around.
        exp_cur = init_q + idx_q;
`ifdef CHK_ERR_INJECT_EN
        if (inj_q && (idx_q == 32'd0)) begin
            exp_cur = exp_cur ^ 32'h1;
        end
`endif

        // The tag enters the delay line on the same edge the BRAM samples the
        // address, so the last stage lines up with ram_din.
        dly_d[0].valid = ram_en_q;
        dly_d[0].addr  = ram_addr_q;
        dly_d[0].expd  = exp_cur;
        for (int i = 1; i < RD_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end

        if (dly_q[RD_LAT-1].valid && (ram_din != dly_q[RD_LAT-1].expd)) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (err_cnt_q == '0) begin
                first_addr_d = dly_q[RD_LAT-1].addr;
                first_data_d = ram_din;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (chk_start) begin
                    init_d       = init_data;
                    n_d          = {2'b00, len[31:2]};
                    idx_d        = 32'd0;
                    err_cnt_d    = '0;
                    first_addr_d = 32'd0;
                    first_data_d = 32'd0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
`ifdef CHK_ERR_INJECT_EN
                    inj_d        = err_inj;
`endif
                    if (len[31:2] == 30'd0) begin
                        state_d = S_DONE;
                    end else begin
                        ram_en_d   = 1'b1;
                        ram_addr_d = start_addr;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (idx_q == n_q - 32'd1) begin
                    ram_en_d    = 1'b0;
                    drain_cnt_d = 2'd0;
                    state_d     = S_DRAIN;
                end else begin
                    ram_addr_d = ram_addr_q + 32'd4;
                    idx_d      = idx_q + 32'd1;
                end
            end
            S_DRAIN: begin
                // The last compare happens on the edge that leaves DRAIN.
                if (drain_cnt_q == 2'(RD_LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_cnt_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any sweep immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments throughout so every flop samples
            // the pre-edge values regardless of statement order.
            state_q      <= S_IDLE;
            ram_en_q     <= 1'b0;
            ram_addr_q   <= 32'd0;
            idx_q        <= 32'd0;
            n_q          <= 32'd0;
            init_q       <= 32'd0;
            drain_cnt_q  <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            first_addr_q <= 32'd0;
            first_data_q <= 32'd0;
`ifdef CHK_ERR_INJECT_EN
            inj_q        <= 1'b0;
`endif
            // NOTE: the delay line is reset because a stale valid bit would
            // fire a compare after reset; it is only RD_LAT entries deep.
            for (int i = 0; i < RD_LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ram_en_q     <= ram_en_d;
            ram_addr_q   <= ram_addr_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            init_q       <= init_d;
            drain_cnt_q  <= drain_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            first_addr_q <= first_addr_d;
            first_data_q <= first_data_d;
`ifdef CHK_ERR_INJECT_EN
            inj_q        <= inj_d;
`endif
            for (int i = 0; i < RD_LAT; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    assign ram_en         = ram_en_q;
    assign ram_addr       = ram_addr_q;
    assign ram_we         = 4'h0;
    assign ram_rst        = 1'b0;
    assign chk_busy       = busy_q;
    assign chk_done       = done_q;
    assign chk_pass       = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_addr_q;
    assign first_err_data = first_data_q;

endmodule

// File: tb/tb_ram_read_check.sv
// tb_ram_read_check: directed read-back checks against a small BRAM model.
// Cycle numbering: the cycle in which chk_start is sampled is cycle 0; the
// cycle after that edge is cycle 1. chk_done is expected high in cycle
// N+RD_LAT+2 (cycle 2 when N==0). Outputs are sampled on the falling edge.
module tb_ram_read_check;

    localparam int RD_LAT = 1;
    localparam int ERR_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      ram_din;
    logic             ram_en;
    logic [3:0]       ram_we;
    logic             ram_rst;
    logic [31:0]      ram_addr;
    logic             chk_start;
    logic [31:0]      start_addr;
    logic [31:0]      len;
    logic [31:0]      init_data;
    logic             chk_busy;
    logic             chk_done;
    logic             chk_pass;
    logic [ERR_W-1:0] err_cnt;
    logic [31:0]      first_err_addr;
    logic [31:0]      first_err_data;
`ifdef CHK_ERR_INJECT_EN
    logic             err_inj;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int en_total = 0;
    int we_bad   = 0;
    int done_total = 0;

    ram_read_check #(.RD_LAT(RD_LAT), .ERR_W(ERR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ram_din        (ram_din),
        .ram_en         (ram_en),
        .ram_we         (ram_we),
        .ram_rst        (ram_rst),
        .ram_addr       (ram_addr),
        .chk_start      (chk_start),
`ifdef CHK_ERR_INJECT_EN
        .err_inj        (err_inj),
`endif
        .start_addr     (start_addr),
        .len            (len),
        .init_data      (init_data),
        .chk_busy       (chk_busy),
        .chk_done       (chk_done),
        .chk_pass       (chk_pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data)
    );

    always #5 clk = ~clk;

    // BRAM model: 64 words indexed by byte address bits [7:2], RD_LAT pipeline.
    logic [31:0] mem [64];
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_en) rd_pipe[0] <= mem[ram_addr[7:2]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_din = rd_pipe[RD_LAT-1];

    // Running counts of reads, illegal writes and done pulses.
    always @(posedge clk) begin
        if (ram_en) en_total++;
        if (ram_we != 4'h0 || ram_rst) we_bad++;
        if (chk_done) done_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(chk_busy), 32'd0);
        check({tag, "_done"}, 32'(chk_done), 32'd0);
        check({tag, "_pass"}, 32'(chk_pass), 32'd0);
        check({tag, "_en"},   32'(ram_en), 32'd0);
        check({tag, "_addr"}, ram_addr, 32'd0);
        check({tag, "_err"},  32'(err_cnt), 32'd0);
        check({tag, "_fa"},   first_err_addr, 32'd0);
        check({tag, "_fd"},   first_err_data, 32'd0);
    endtask

    // Present a start for one sampling edge; returns at the falling edge of cycle 1.
    task automatic start_run(input logic [31:0] a, input logic [31:0] l, input logic [31:0] d);
        @(negedge clk);
        start_addr = a;
        len        = l;
        init_data  = d;
        chk_start  = 1'b1;
        @(negedge clk);
        chk_start  = 1'b0;
    endtask

    // Full sweep with latency and result checks. poke>0 pulses chk_start in that cycle.
    task automatic do_run(input string tag, input logic [31:0] a, input logic [31:0] l,
                          input logic [31:0] d, input int poke, input int exp_err,
                          input logic [31:0] exp_fa, input logic [31:0] exp_fd,
                          input logic exp_pass);
        int cyc;
        int en0;
        int n_words;
        int exp_lat;
        n_words = int'(l >> 2);
        exp_lat = (n_words == 0) ? 2 : n_words + RD_LAT + 2;
        en0 = en_total;
        start_run(a, l, d);
        check({tag, "_busy1"}, 32'(chk_busy), 32'd1);
        cyc = 1;
        while (!chk_done && cyc < 300) begin
            @(negedge clk);
            chk_start = (cyc + 1 == poke);
            if (chk_start) begin
                len = 32'd0;
                start_addr = 32'h80;
            end
            cyc++;
        end
        chk_start = 1'b0;
        check({tag, "_lat"},   32'(cyc), 32'(exp_lat));
        check({tag, "_done"},  32'(chk_done), 32'd1);
        check({tag, "_busy0"}, 32'(chk_busy), 32'd0);
        check({tag, "_pass"},  32'(chk_pass), 32'(exp_pass));
        check({tag, "_err"},   32'(err_cnt), 32'(exp_err));
        check({tag, "_fa"},    first_err_addr, exp_fa);
        check({tag, "_fd"},    first_err_data, exp_fd);
        check({tag, "_reads"}, 32'(en_total - en0), 32'(n_words));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(chk_done), 32'd0);
        check({tag, "_hold"},  32'(chk_pass), 32'(exp_pass));
    endtask

    initial begin
        int d0;
        rst        = 1'b1;
        chk_start  = 1'b0;
        start_addr = 32'd0;
        len        = 32'd0;
        init_data  = 32'd0;
`ifdef CHK_ERR_INJECT_EN
        err_inj    = 1'b0;
`endif
        for (int k = 0; k < 64; k++) mem[k] = 32'd0;
        for (int k = 0; k < 16; k++) begin
            mem[k]      = 32'h100 + 32'(k);
            mem[16 + k] = 32'h5000 + 32'(k);
        end
        mem[32] = 32'hFFFF_FFFE;
        mem[33] = 32'hFFFF_FFFF;
        mem[34] = 32'h0000_0000;
        mem[35] = 32'h0000_0001;
        mem[62] = 32'h0000_00FE;
        mem[63] = 32'h0000_00FF;

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean 16-word ramp.
        do_run("ramp", 32'h0, 32'd64, 32'h100, 0, 0, 32'h0, 32'h0, 1'b1);

        // Single corrupted word.
        mem[5] = 32'h0000_DEAD;
        do_run("bad5", 32'h0, 32'd64, 32'h100, 0, 1, 32'h14, 32'hDEAD, 1'b0);
        mem[5] = 32'h105;

        // Two corrupted words: first one captured, count is 2.
        mem[3] = 32'h0;
        mem[7] = 32'hFFFF;
        do_run("bad2", 32'h0, 32'd64, 32'h100, 0, 2, 32'hC, 32'h0, 1'b0);
        mem[3] = 32'h103;
        mem[7] = 32'h107;

        // Empty regions.
        do_run("len0", 32'h80, 32'd0, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1);
        do_run("len3", 32'h80, 32'd3, 32'h0, 0, 0, 32'h0, 32'h0, 1'b1);

        // Expected value wraps through zero.
        do_run("dwrap", 32'h80, 32'd16, 32'hFFFF_FFFE, 0, 0, 32'h0, 32'h0, 1'b1);

        // Address wraps through zero: FFFFFFF8, FFFFFFFC, 0, 4.
        do_run("awrap", 32'hFFFF_FFF8, 32'd16, 32'hFE, 0, 0, 32'h0, 32'h0, 1'b1);

        // Start pulsed mid-run is ignored.
        do_run("restart", 32'h0, 32'd64, 32'h100, 6, 0, 32'h0, 32'h0, 1'b1);

        // Reset mid-run aborts with no done pulse.
        start_run(32'h0, 32'd64, 32'h100);
        repeat (4) @(negedge clk);
        d0 = done_total;
        rst = 1'b1;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_nodone", 32'(done_total - d0), 32'd0);
        check("abort_idle", 32'(chk_busy), 32'd0);

        // Normal run afterwards, nonzero base, len[1:0] ignored.
        do_run("after", 32'h40, 32'd67, 32'h5000, 0, 0, 32'h0, 32'h0, 1'b1);

`ifdef CHK_ERR_INJECT_EN
        err_inj = 1'b1;
        do_run("inject", 32'h0, 32'd64, 32'h100, 0, 1, 32'h0, 32'h100, 1'b0);
        err_inj = 1'b0;
`endif

        check("never_write", 32'(we_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
